unary_serializer: RTL
=====================

// Module: unary_serializer
// PURPOSE
//  Inverse of the population-count blocks: accepts a count N over a valid/ready
//  handshake and emits a WIDTH-bit frame, one bit per transfer, LSB first.
//  Frame bits 0..N-1 are 1 and bits N..WIDTH-1 are 0, so the popcount of each frame equals N.
//  Sits between count-producing logic and serial consumers: pulse-density outputs,
//  popcount round-trip checking.
// PARAMETERS
//  WIDTH  5  frame length in bits (>=2)
//  CW     $clog2(WIDTH+1)  count width (localparam, derived; default 3)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      count request valid
//  in_ready   out  1      block can accept a count this cycle
//  in_cnt     in   CW     requested number of ones, 0..2^CW-1
//  out_valid  out  1      out_bit/out_last valid
//  out_ready  in   1      consumer accepts current bit
//  out_bit    out  1      current frame bit
//  out_last   out  1      current bit is bit WIDTH-1 of the frame
//  err        out  1      one-cycle pulse: out-of-range count dropped
// BEHAVIOUR
//  - Reset (async, while high): state=IDLE, idx=0, cnt_q=0;
//    out_valid=0, out_bit=0, out_last=0, err=0, in_ready=0.
//  - Any frame in progress is abandoned with no partial completion.
//  - States: IDLE, SEND.
//  - in_ready = !reset && (IDLE || (SEND && out_ready && out_last)), combinational.
//    This gives back-to-back frames with no bubble.
//  - Accept = in_valid && in_ready. Registers cnt_q<=in_cnt and idx<=0.
//    Enters SEND next cycle (latency 1 from accept to first out_valid).
//  - SEND: out_valid=1, out_bit=(idx<cnt_q), out_last=(idx==WIDTH-1).
//    These outputs are held stable while out_ready=0.
//  - Transfer = out_valid && out_ready: idx<=idx+1.
//    On the last transfer, go to IDLE, or reload and stay in SEND if a new accept happens in the same cycle.
//  - idx never wraps past WIDTH-1. Frames are always exactly WIDTH transfers.
//  - in_cnt==0 gives an all-zero frame. in_cnt==WIDTH gives an all-one frame.
//    Both are still emitted in full.
//  - in_cnt>WIDTH: see CONFIGURATION.
//  - Compares are done at CW bits, unsigned. idx is CW bits wide.
//  - out_valid never drops mid-frame regardless of out_ready.
//  - in_valid while in_ready=0 is ignored; the upstream must hold it.
// CONFIGURATION
//  UNARY_SER_SAT_EN defined:
//   - in_cnt>WIDTH is clamped to WIDTH, giving an all-one frame.
//   - err is tied to 0.
//  UNARY_SER_SAT_EN undefined:
//   - in_cnt>WIDTH is still consumed (handshake completes) but no frame is emitted.
//   - State stays or returns to IDLE.
//   - err pulses high for exactly the cycle after the accept.
//   - A back-to-back out-of-range accept on the last beat ends the frame normally, then pulses err.
// STRUCTURE
//  - Shared package unary_pkg: state encoding (IDLE=1'b0, SEND=1'b1) and the
//    count-width helper function cw(width)=$clog2(width+1), also used by the popcount blocks.
//  - No sub-module: one FSM plus one index counter, in a single module.
// TESTING
//  - Reset, then in_cnt=3 accepted, out_ready=1:
//    out_bit=1,1,1,0,0 on 5 consecutive cycles, out_last on the 5th, in_ready high on that cycle.
//  - in_cnt=0, then in_cnt=5 back-to-back, out_ready=1:
//    00000 then 11111 with no idle cycle between frames.
//  - in_cnt=2, out_ready toggling 1,0,0,1...:
//    out_bit/out_last hold during stalls; frame 11000 completes in 5 transfers.
//  - in_cnt=7, macro undefined: err=1 for one cycle, no out_valid, in_ready=1 next cycle.
//    Same input with UNARY_SER_SAT_EN defined: frame 11111, err stays 0.
//  - reset asserted after 2 of 5 bits: outputs go 0 immediately.
//    After release, in_ready=1 and a new in_cnt=1 gives 10000.
//  - Random counts 0..5 with random out_ready: popcount of each captured frame == request.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared definitions for the unary serializer and the popcount blocks:
// FSM state encoding and the count-width helper.
package unary_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Bits needed to hold a count in 0..width inclusive.
    function automatic int cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/unary_serializer.sv
// Turns a count N into a WIDTH-bit LSB-first frame of N ones followed by zeros.
// Define UNARY_SER_SAT_EN to clamp out-of-range counts instead of dropping them.
module unary_serializer
    import unary_pkg::*;
#(
    parameter int  WIDTH = 5,
    localparam int CW    = cw(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_last,
    output logic          err
);

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_last_q, out_last_d;
    logic          err_q, err_d;

    logic          accept;
    logic          transfer;
    logic          cnt_oor;
    logic          drop;
    logic [CW-1:0] cnt_eff;
    logic [CW-1:0] idx_inc;

    // A new count is taken while idle or on the final beat, so frames run back to back.
    assign in_ready = !reset && ((state_q == IDLE) ||
                                 ((state_q == SEND) && out_ready && out_last_q));
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;
    assign cnt_oor  = in_cnt > CW'(WIDTH);
    assign idx_inc  = idx_q + CW'(1);

`ifdef UNARY_SER_SAT_EN
    assign cnt_eff = cnt_oor ? CW'(WIDTH) : in_cnt;
    assign drop    = 1'b0;
`else
    assign cnt_eff = in_cnt;
    assign drop    = cnt_oor;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        if (accept && drop) begin
            state_d     = IDLE;
            idx_d       = '0;
            cnt_d       = in_cnt;
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            out_last_d  = 1'b0;
            err_d       = 1'b1;
        end else if (accept) begin
            state_d     = SEND;
            idx_d       = '0;
            cnt_d       = cnt_eff;
            out_valid_d = 1'b1;
            out_bit_d   = (cnt_eff != '0);
            out_last_d  = 1'b0;
        end else if (transfer) begin
            if (out_last_q) begin
                state_d     = IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
                out_bit_d   = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                idx_d      = idx_inc;
                out_bit_d  = (idx_inc < cnt_q);
                out_last_d = (idx_inc == CW'(WIDTH - 1));
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule
